// File: rtl/irrigation_countdown_if.sv
// Control/status bundle between the irrigation controller and the countdown timer.
// The master side drives start/duration/pause/abort; the slave side returns valve, status and a..g.
interface irrigation_countdown_if;
  logic       start;
  logic [3:0] duration;
  logic       pause;
  logic       abort;
  logic       valve;
  logic       busy;
  logic       done;
  logic       selector;
  logic       a, b, c, d, e, f, g;

  modport master (
    output start, duration, pause, abort,
    input  valve, busy, done, selector, a, b, c, d, e, f, g
  );

  modport slave (
    input  start, duration, pause, abort,
    output valve, busy, done, selector, a, b, c, d, e, f, g
  );
endinterface

// File: rtl/irrigation_countdown.sv
// Irrigation-cycle countdown timer: drives the valve and one seven-segment digit of remaining time.
// Optional feature COUNTDOWN_BLINK_EN: blanks the digit on alternate half-units while paused.
module irrigation_countdown #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned HOLD_TICKS  = 2
) (
  input logic                   clk,
  input logic                   reset_n,
  irrigation_countdown_if.slave bus
);

  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        remaining, remaining_nxt;
  logic [TICK_W-1:0] tick_cnt, tick_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic       valve_q, busy_q, done_q, selector_q;
  logic [6:0] seg_q;
  logic       valve_nxt, busy_nxt, done_nxt, selector_nxt;
  logic [6:0] seg_nxt;
  logic       legal_start_c;
  logic       tick_end_c;
  logic       blank_c;

  // a..g encoding of one decimal digit
  function automatic logic [6:0] digit_seg(input logic [3:0] dgt);
    case (dgt)
      4'd0:    digit_seg = 7'b1111110;
      4'd1:    digit_seg = 7'b0110000;
      4'd2:    digit_seg = 7'b1101101;
      4'd3:    digit_seg = 7'b1111001;
      4'd4:    digit_seg = 7'b0110011;
      4'd5:    digit_seg = 7'b1011011;
      4'd6:    digit_seg = 7'b1011111;
      4'd7:    digit_seg = 7'b1110000;
      4'd8:    digit_seg = 7'b1111111;
      4'd9:    digit_seg = 7'b1111011;
      default: digit_seg = 7'b0000000;
    endcase
  endfunction

  assign legal_start_c = bus.start && (bus.duration != 4'd0) && (bus.duration <= 4'd9);
  assign tick_end_c    = (tick_cnt == TICK_MAX);

  // State register plus registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      remaining  <= 4'd0;
      tick_cnt   <= '0;
      hold_cnt   <= '0;
      valve_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      selector_q <= 1'b0;
      seg_q      <= 7'b0000000;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      tick_cnt   <= tick_nxt;
      hold_cnt   <= hold_nxt;
      valve_q    <= valve_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      selector_q <= selector_nxt;
      seg_q      <= seg_nxt;
    end
  end

  // Next state, counters and output values; abort overrides everything
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    tick_nxt      = tick_cnt;
    hold_nxt      = hold_cnt;
    done_nxt      = 1'b0;

    if (bus.abort) begin
      state_nxt     = IDLE;
      remaining_nxt = 4'd0;
      tick_nxt      = '0;
      hold_nxt      = '0;
    end else begin
      case (state)
        IDLE: begin
          if (legal_start_c) begin
            state_nxt     = RUN;
            remaining_nxt = bus.duration;
            tick_nxt      = '0;
          end
        end
        RUN: begin
          // pause wins over a coincident tick: the fraction is kept intact
          if (bus.pause) begin
            state_nxt = PAUSE;
          end else if (tick_end_c) begin
            tick_nxt = '0;
            if (remaining == 4'd1) begin
              state_nxt     = DONE;
              remaining_nxt = 4'd0;
              done_nxt      = 1'b1;
              hold_nxt      = '0;
            end else begin
              remaining_nxt = remaining - 4'd1;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
        PAUSE: begin
          if (!bus.pause) state_nxt = RUN;
        end
        DONE: begin
          // restart beats hold expiry
          if (legal_start_c) begin
            state_nxt     = RUN;
            remaining_nxt = bus.duration;
            tick_nxt      = '0;
          end else if (tick_end_c) begin
            tick_nxt = '0;
            if (hold_cnt == HOLD_MAX) begin
              state_nxt = IDLE;
              hold_nxt  = '0;
            end else begin
              hold_nxt = hold_cnt + HOLD_W'(1);
            end
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
        default: begin
          state_nxt     = IDLE;
          remaining_nxt = 4'd0;
          tick_nxt      = '0;
          hold_nxt      = '0;
        end
      endcase
    end

    valve_nxt    = (state_nxt == RUN);
    busy_nxt     = (state_nxt == RUN) || (state_nxt == PAUSE);
    selector_nxt = (state_nxt != IDLE);
    if (state_nxt == IDLE || blank_c) seg_nxt = 7'b0000000;
    else                               seg_nxt = digit_seg(remaining_nxt);
  end

`ifdef COUNTDOWN_BLINK_EN
  localparam int unsigned HALF_CYCLES = (TICK_CYCLES / 2 > 1) ? TICK_CYCLES / 2 : 1;
  localparam int unsigned BLINK_W     = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] HALF_MAX = BLINK_W'(HALF_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  logic               blink_off, blink_off_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_off <= blink_off_nxt;
    end
  end

  // Half-unit phase counter, restarted in the visible phase on every PAUSE entry
  always_comb begin
    blink_cnt_nxt = '0;
    blink_off_nxt = 1'b0;
    if (state_nxt == PAUSE && state == PAUSE) begin
      if (blink_cnt == HALF_MAX) begin
        blink_cnt_nxt = '0;
        blink_off_nxt = ~blink_off;
      end else begin
        blink_cnt_nxt = blink_cnt + BLINK_W'(1);
        blink_off_nxt = blink_off;
      end
    end
  end

  assign blank_c = (state_nxt == PAUSE) && blink_off_nxt;
`else
  assign blank_c = 1'b0;
`endif

  assign bus.valve    = valve_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.selector = selector_q;
  assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_q;

endmodule

// File: tb/tb_irrigation_countdown.sv
// Self-checking bench for irrigation_countdown with TICK_CYCLES=4, HOLD_TICKS=2.
// Table-driven single-cycle vectors followed by hand-written multi-cycle sequences.
module tb_irrigation_countdown;
  localparam int unsigned TICK = 4;
  localparam int unsigned HOLD = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  irrigation_countdown_if bus();

  irrigation_countdown #(.TICK_CYCLES(TICK), .HOLD_TICKS(HOLD)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [10:0] obs;
  assign obs = {bus.valve, bus.busy, bus.done, bus.selector,
                bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};

  function automatic logic [6:0] seg(input int dgt);
    case (dgt)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // expected {valve,busy,done,selector,a..g} for each state
  function automatic logic [10:0] x_run(input int dgt);
    return {4'b1101, seg(dgt)};
  endfunction
  function automatic logic [10:0] x_pause(input int dgt, input int p);
`ifdef COUNTDOWN_BLINK_EN
    if (((p / 2) % 2) == 1) return {4'b0101, 7'b0000000};
`endif
    return {4'b0101, seg(dgt)};
  endfunction
  function automatic logic [10:0] x_done(input logic pulse);
    return {2'b00, pulse, 1'b1, seg(0)};
  endfunction
  localparam logic [10:0] X_IDLE = 11'b0;

  task automatic chk(input string name, input int k, input logic [10:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%b exp=%b", name, k, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [3:0] dur, input logic pa, input logic ab);
    bus.start    = st;
    bus.duration = dur;
    bus.pause    = pa;
    bus.abort    = ab;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        st;
    logic [3:0]  dur;
    logic        pa;
    logic        ab;
    logic [10:0] exp;
  } vec_t;

  vec_t vt[11];

  initial begin
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk("reset", 0, X_IDLE);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // single-cycle vectors: illegal starts, abort priority, start ignored in RUN
    vt[0]  = '{1'b1, 4'd0,  1'b0, 1'b0, X_IDLE};
    vt[1]  = '{1'b1, 4'd12, 1'b0, 1'b0, X_IDLE};
    vt[2]  = '{1'b0, 4'd5,  1'b0, 1'b0, X_IDLE};
    vt[3]  = '{1'b1, 4'd15, 1'b0, 1'b0, X_IDLE};
    vt[4]  = '{1'b1, 4'd4,  1'b0, 1'b1, X_IDLE};
    vt[5]  = '{1'b1, 4'd3,  1'b0, 1'b0, x_run(3)};
    vt[6]  = '{1'b0, 4'd3,  1'b0, 1'b0, x_run(3)};
    vt[7]  = '{1'b1, 4'd9,  1'b0, 1'b0, x_run(3)};
    vt[8]  = '{1'b0, 4'd0,  1'b0, 1'b0, x_run(3)};
    vt[9]  = '{1'b0, 4'd0,  1'b0, 1'b0, x_run(2)};
    vt[10] = '{1'b1, 4'd5,  1'b0, 1'b1, X_IDLE};
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].st, vt[i].dur, vt[i].pa, vt[i].ab);
      cyc();
      chk("vector", i, vt[i].exp);
    end

    // nominal 3-unit cycle through DONE hold back to IDLE
    for (int k = 0; k <= 21; k++) begin
      drive(k == 0, 4'd3, 1'b0, 1'b0);
      cyc();
      if (k < 12)       chk("nominal", k, x_run(3 - k / 4));
      else if (k == 12) chk("nominal", k, x_done(1'b1));
      else if (k < 20)  chk("nominal", k, x_done(1'b0));
      else              chk("nominal", k, X_IDLE);
    end

    // restart on the same edge the hold would expire
    for (int k = 0; k <= 13; k++) begin
      drive((k == 0) || (k == 12), (k == 12) ? 4'd6 : 4'd1, 1'b0, 1'b0);
      cyc();
      if (k < 4)        chk("restart", k, x_run(1));
      else if (k == 4)  chk("restart", k, x_done(1'b1));
      else if (k < 12)  chk("restart", k, x_done(1'b0));
      else              chk("restart", k, x_run(6));
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1); cyc(); chk("restart_abort", 0, X_IDLE);

    // pause for 10 cycles after 2 RUN cycles; fraction preserved on resume
    for (int k = 0; k <= 15; k++) begin
      drive(k == 0, 4'd2, (k >= 3) && (k <= 12), 1'b0);
      cyc();
      if (k < 3)        chk("pause", k, x_run(2));
      else if (k <= 12) chk("pause", k, x_pause(2, k - 3));
      else if (k < 15)  chk("pause", k, x_run(2));
      else              chk("pause", k, x_run(1));
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1); cyc(); chk("pause_abort", 0, X_IDLE);

    // pause coincident with tick end: no decrement, then finish to DONE
    for (int k = 0; k <= 10; k++) begin
      drive(k == 0, 4'd2, k == 4, 1'b0);
      cyc();
      if (k < 4)        chk("pause_tick", k, x_run(2));
      else if (k == 4)  chk("pause_tick", k, x_pause(2, 0));
      else if (k == 5)  chk("pause_tick", k, x_run(2));
      else if (k < 10)  chk("pause_tick", k, x_run(1));
      else              chk("pause_tick", k, x_done(1'b1));
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1); cyc(); chk("done_abort", 0, X_IDLE);

    // abort on the tick that would reach zero: no done pulse
    for (int k = 0; k <= 6; k++) begin
      drive(k == 0, 4'd1, 1'b0, k == 4);
      cyc();
      if (k < 4) chk("abort_tick", k, x_run(1));
      else       chk("abort_tick", k, X_IDLE);
    end

    // asynchronous reset between edges
    drive(1'b1, 4'd4, 1'b0, 1'b0); cyc();
    drive(1'b0, 4'd4, 1'b0, 1'b0); cyc();
    chk("pre_reset", 0, x_run(4));
    #2 reset_n = 1'b0;
    #1 chk("async_reset", 0, X_IDLE);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_reset", 0, X_IDLE);
    drive(1'b1, 4'd9, 1'b0, 1'b0); cyc(); chk("start9", 0, x_run(9));
    drive(1'b0, 4'd0, 1'b0, 1'b1); cyc(); chk("start9_abort", 0, X_IDLE);

    // pause at "5": steady or blinking depending on build
    for (int k = 0; k <= 7; k++) begin
      drive(k == 0, 4'd5, k >= 1, 1'b0);
      cyc();
      if (k == 0) chk("blink", k, x_run(5));
      else        chk("blink", k, x_pause(5, k - 1));
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1); cyc(); chk("blink_abort", 0, X_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
